ci_sample_sequencer: RTL and testbench
======================================

Name: ci_sample_sequencer

Overview:
- Custom-instruction initiator: autonomously issues CI read transactions to a profiling-counter responder (same start/ciN/valueA/valueB/done/result protocol the CPU uses) and streams captured counter values out over a valid/ready port.
- Sits beside the CPU CI bus, in front of the profiling CI.
- Gives periodic snapshots of all counters without software polling.

Parameters:
- CUSTOM_ID, 8'd8, CI number driven on ciN.
- NUM_COUNTERS, 4, counters read per frame (indices 0..NUM_COUNTERS-1 on valueA[1:0]).
- TIMEOUT, 16, max cycles waiting for ciDone after ciStart.
- SEQ_WIDTH, 8, frame sequence-number width.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  run periodic sampling
- period  in  32  cycles between frame starts; 0 treated as 1
- snapReq  in  1  one-cycle pulse: start a frame now (ignored if a frame is in progress)
- controlWord  in  12  driven on ciValueB[11:0] every transaction; ciValueB[31:12]=0
- ciStart  out  1  CI start strobe
- ciN  out  8  CI number (constant CUSTOM_ID while ciStart=1, else 0)
- ciValueA  out  32  counter index, zero-extended
- ciValueB  out  32  {20'b0, controlWord}
- ciDone  in  1  responder done
- ciResult  in  32  responder result, valid when ciDone=1
- sampleValid  out  1  output sample valid
- sampleReady  in  1  consumer ready
- sampleData  out  32  captured counter value
- sampleIndex  out  2  counter index of sample
- sampleSeq  out  SEQ_WIDTH  frame sequence number
- sampleTimeout  out  1  sample aborted by timeout (sampleData=0)
- busy  out  1  frame in progress
- timeoutCount  out  8  saturating count of timed-out transactions

Behaviour:
- Reset: all outputs 0, state IDLE, tick counter 0, seq 0, timeoutCount 0. Reset mid-transaction aborts immediately. No held sample is delivered.
- States:
  - IDLE: wait for a trigger.
  - ISSUE: exactly one cycle; ciStart=1, ciN/ciValueA/ciValueB valid.
  - WAIT: ciStart=0; count cycles.
  - OUT: sampleValid=1; wait for sampleReady.
  - NEXT: advance index or end the frame.
- Tick counter: runs while enable=1. On reaching period-1 (or immediately if period is 0 or 1), a trigger is raised and the counter reloads to 0. If enable=0, the counter is held at 0.
- Trigger: periodic tick or snapReq. Accepted only in IDLE; triggers arriving while busy are dropped, not queued. Tick and snapReq in the same cycle give one frame.
- Frame start: index=0, busy=1, go to ISSUE next cycle.
- ISSUE: if ciDone=1 in the same cycle (combinational responder), capture ciResult and go to OUT; otherwise go to WAIT with wait counter 1.
- WAIT: ciDone=1 captures ciResult and goes to OUT. If the wait counter reaches TIMEOUT with no done, go to OUT with data=0, sampleTimeout=1, and timeoutCount+1 (saturating at 255). ciDone outside ISSUE/WAIT is ignored.
- OUT: sampleData/Index/Seq/Timeout are registered and stable while sampleValid=1 && !sampleReady. Transfer occurs when sampleValid && sampleReady; sampleValid drops the next cycle.
- NEXT: if index==NUM_COUNTERS-1, increment seq (wraps at 2^SEQ_WIDTH), busy=0, go to IDLE; else index+1 and go to ISSUE. NEXT takes one cycle.
- Latency: with a combinational responder and sampleReady=1, each sample takes 3 cycles (ISSUE, OUT, NEXT); a 4-counter frame takes 12 cycles from ISSUE of index 0 to IDLE.
- ciStart is never high for two consecutive cycles.
- enable deasserted mid-frame: the frame completes; no new periodic triggers follow.

Decomposition:
- Shared package ci_pkg:
  - CI_PROFILE_ID = 8'd8
  - state enum {IDLE, ISSUE, WAIT, OUT, NEXT}
  - control-word bit constants: EN[3:0], DIS[7:4], CLR[11:8]
- Sub-module ci_period_timer: tick counter with enable/period/reload. The FSM stays in the top module.

Test Plan:
- Combinational responder (done=start, result=32'h100+index), period=20, sampleReady=1 → samples 0x100..0x103, indices 0..3, seq 0; next frame seq 1 starts 20 cycles after the first.
- Responder asserting done 3 cycles after start with result 0xDEAD_BEEF → sample captured, ciStart high exactly one cycle per transaction.
- Responder never asserts done, TIMEOUT=16 → each sample has data 0 and sampleTimeout=1, arriving 16 cycles after ISSUE; timeoutCount=4 after the frame.
- sampleReady held low 10 cycles during index 1 → sampleData/Index stable, no ciStart issued until transfer.
- snapReq while busy and snapReq coinciding with tick → no extra frame; exactly one frame per trigger window.
- reset asserted during WAIT → next cycle all outputs 0, IDLE; a late ciDone is ignored; seq restarts at 0.

Source files
------------

// File: rtl/ci_pkg.sv
// rtl/ci_pkg.sv - shared CI identifiers, sequencer states and control-word fields
package ci_pkg;

    localparam logic [7:0] CI_PROFILE_ID = 8'd8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        NEXT
    } seq_state_e;

    // controlWord field masks as seen by the profiling counters
    localparam logic [11:0] CW_EN  = 12'h00F;
    localparam logic [11:0] CW_DIS = 12'h0F0;
    localparam logic [11:0] CW_CLR = 12'hF00;

endpackage

// File: rtl/ci_sample_sequencer_if.sv
// rtl/ci_sample_sequencer_if.sv - CI initiator bus plus captured-sample stream
interface ci_sample_sequencer_if #(
    parameter int SEQ_WIDTH = 8
);
    logic                 ciStart;
    logic [7:0]           ciN;
    logic [31:0]          ciValueA;
    logic [31:0]          ciValueB;
    logic                 ciDone;
    logic [31:0]          ciResult;

    logic                 sampleValid;
    logic                 sampleReady;
    logic [31:0]          sampleData;
    logic [1:0]           sampleIndex;
    logic [SEQ_WIDTH-1:0] sampleSeq;
    logic                 sampleTimeout;

    modport master (
        output ciStart, ciN, ciValueA, ciValueB,
        input  ciDone, ciResult,
        output sampleValid, sampleData, sampleIndex, sampleSeq, sampleTimeout,
        input  sampleReady
    );

    modport slave (
        input  ciStart, ciN, ciValueA, ciValueB,
        output ciDone, ciResult,
        input  sampleValid, sampleData, sampleIndex, sampleSeq, sampleTimeout,
        output sampleReady
    );

endinterface

// File: rtl/ci_period_timer.sv
// rtl/ci_period_timer.sv - free-running frame tick generator, held at zero while disabled
module ci_period_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [31:0] period_i,
    output logic        tick_o
);

    logic [31:0] cnt_q, cnt_d;

    // >= keeps the counter from running to wrap if period shrinks mid-count
    always_comb begin
        tick_o = 1'b0;
        cnt_d  = 32'd0;
        if (enable_i) begin
            if (period_i <= 32'd1 || cnt_q >= period_i - 32'd1) begin
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ci_sample_sequencer.sv
// rtl/ci_sample_sequencer.sv - autonomous CI reader that streams profiling-counter snapshots
module ci_sample_sequencer
    import ci_pkg::*;
#(
    parameter logic [7:0] CUSTOM_ID    = CI_PROFILE_ID,
    parameter int         NUM_COUNTERS = 4,
    parameter int         TIMEOUT      = 16,
    parameter int         SEQ_WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           period,
    input  logic                  snapReq,
    input  logic [11:0]           controlWord,
    ci_sample_sequencer_if.master bus,
    output logic                  busy,
    output logic [7:0]            timeoutCount
);

    localparam int         WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_COUNTERS - 1);

    seq_state_e           state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [31:0]          data_q, data_d;
    logic                 to_q, to_d;
    logic [SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [7:0]           tcnt_q, tcnt_d;
    logic                 tick;
    logic                 ci_start;

    ci_period_timer u_timer (
        .clock    (clock),
        .reset    (reset),
        .enable_i (enable),
        .period_i (period),
        .tick_o   (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        data_d  = data_q;
        to_d    = to_q;
        seq_d   = seq_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (tick || snapReq) begin
                    idx_d   = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // a combinational responder may answer in the strobe cycle itself
                if (bus.ciDone) begin
                    data_d  = bus.ciResult;
                    to_d    = 1'b0;
                    state_d = OUT;
                end else begin
                    wait_d  = WAIT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.ciDone) begin
                    data_d  = bus.ciResult;
                    to_d    = 1'b0;
                    state_d = OUT;
                end else if (wait_q >= WAIT_W'(TIMEOUT - 1)) begin
                    data_d  = 32'd0;
                    to_d    = 1'b1;
                    state_d = OUT;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            OUT: begin
                if (bus.sampleReady) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    seq_d   = seq_q + SEQ_WIDTH'(1);
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            wait_q  <= '0;
            data_q  <= 32'd0;
            to_q    <= 1'b0;
            seq_q   <= '0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            to_q    <= to_d;
            seq_q   <= seq_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // request fields are zeroed outside the strobe so the bus idles quiet
    assign ci_start          = (state_q == ISSUE);
    assign bus.ciStart       = ci_start;
    assign bus.ciN           = ci_start ? CUSTOM_ID : 8'd0;
    assign bus.ciValueA      = ci_start ? {30'd0, idx_q} : 32'd0;
    assign bus.ciValueB      = ci_start ? {20'd0, controlWord} : 32'd0;

    assign bus.sampleValid   = (state_q == OUT);
    assign bus.sampleData    = data_q;
    assign bus.sampleIndex   = idx_q;
    assign bus.sampleSeq     = seq_q;
    assign bus.sampleTimeout = to_q;

    assign busy              = (state_q != IDLE);
    assign timeoutCount      = tcnt_q;

endmodule

// File: tb/tb_ci_sample_sequencer.sv
// tb/tb_ci_sample_sequencer.sv - scoreboard bench with randomized responder latency and backpressure
module tb_ci_sample_sequencer;
    import ci_pkg::*;

    localparam int NC    = 4;
    localparam int TMO   = 16;
    localparam int NEVER = 255;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        logic [7:0]  seq;
        logic        to;
    } smp_t;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic [31:0] period      = 32'd20;
    logic        snapReq     = 1'b0;
    logic [11:0] controlWord = 12'h000;
    logic        busy;
    logic [7:0]  timeoutCount;

    ci_sample_sequencer_if #(.SEQ_WIDTH(8)) bus();

    ci_sample_sequencer #(
        .CUSTOM_ID    (CI_PROFILE_ID),
        .NUM_COUNTERS (NC),
        .TIMEOUT      (TMO),
        .SEQ_WIDTH    (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .snapReq      (snapReq),
        .controlWord  (controlWord),
        .bus          (bus),
        .busy         (busy),
        .timeoutCount (timeoutCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // reference model: every frame reads indices 0..NC-1 in order, seq counts frames
    int   m_idx      = 0;
    int   m_seq      = 0;
    int   m_tout     = 0;
    int   mode       = 0;
    int   ready_mode = 0;
    int   hold_cnt   = 0;
    bit   hold_arm   = 1'b0;
    smp_t exp_q[$];
    int   arr_q[$];
    int   start_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // responder: decides latency/result per transaction and predicts the sample
    initial begin
        bus.ciDone   = 1'b0;
        bus.ciResult = 32'h0;
        forever begin
            @(negedge clock);
            if (!reset && bus.ciStart) begin
                int          lat;
                int          r;
                logic [31:0] res;
                smp_t        s;
                case (mode)
                    0: begin lat = 0; res = 32'h100 + 32'(m_idx); end
                    1: begin
                        r   = $urandom_range(0, 9);
                        lat = (r == 0) ? NEVER : (r == 1) ? TMO : (r == 2) ? TMO - 1 : $urandom_range(0, 5);
                        res = $urandom;
                    end
                    2: begin lat = 3; res = 32'hDEAD_BEEF; end
                    3: begin lat = NEVER; res = 32'h0; end
                    4: begin lat = (m_idx % 2 == 0) ? TMO - 1 : TMO; res = $urandom; end
                    default: begin lat = 6; res = 32'h1234_5678; end
                endcase
                chk("ciN", bus.ciN, CI_PROFILE_ID);
                chk("ciValueA", bus.ciValueA, m_idx);
                chk("ciValueB", bus.ciValueB, {20'd0, controlWord});
                if (m_idx == 0) start_q.push_back(cyc);
                s.data = (lat >= TMO) ? 32'h0 : res;
                s.idx  = m_idx[1:0];
                s.seq  = m_seq[7:0];
                s.to   = (lat >= TMO);
                exp_q.push_back(s);
                arr_q.push_back(cyc + ((lat >= TMO) ? TMO : lat + 1));
                if (lat >= TMO && m_tout < 255) m_tout++;
                if (m_idx == NC - 1) begin
                    m_idx = 0;
                    m_seq = (m_seq + 1) % 256;
                end else begin
                    m_idx++;
                end
                if (lat != NEVER) begin
                    repeat (lat) @(negedge clock);
                    bus.ciDone   = 1'b1;
                    bus.ciResult = res;
                    @(negedge clock);
                    bus.ciDone   = 1'b0;
                    bus.ciResult = $urandom;
                end
            end
        end
    end

    // consumer: drives sampleReady, then checks bus protocol and pops the scoreboard
    logic prev_start = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    smp_t held;
    initial begin
        bus.sampleReady = 1'b0;
        forever begin
            @(negedge clock);
            if (hold_arm && bus.sampleValid && bus.sampleIndex == 2'd1) begin
                hold_arm = 1'b0;
                hold_cnt = 10;
            end
            if (hold_cnt > 0) begin
                bus.sampleReady = 1'b0;
                hold_cnt--;
            end else if (ready_mode == 0) begin
                bus.sampleReady = 1'b1;
            end else begin
                bus.sampleReady = ($urandom_range(0, 3) != 0);
            end
            if (!reset) begin
                if (bus.ciStart) chk("ciStart_single", prev_start, 0);
                else chk("ciN_idle", bus.ciN, 0);
                if (bus.sampleValid) begin
                    chk("busy_in_out", busy, 1);
                    chk("no_start_in_out", bus.ciStart, 0);
                    if (!prev_valid) begin
                        if (arr_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL arrival: unexpected sample at cycle %0d, expected none", cyc);
                        end else begin
                            chk("arrival_cycle", cyc, arr_q.pop_front());
                        end
                    end else if (!prev_ready) begin
                        chk("stable_data", bus.sampleData, held.data);
                        chk("stable_index", bus.sampleIndex, held.idx);
                        chk("stable_seq", bus.sampleSeq, held.seq);
                        chk("stable_timeout", bus.sampleTimeout, held.to);
                    end
                    if (bus.sampleReady) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL sample: unexpected transfer data %0h, expected none", bus.sampleData);
                        end else begin
                            smp_t e;
                            e = exp_q.pop_front();
                            chk("sampleData", bus.sampleData, e.data);
                            chk("sampleIndex", bus.sampleIndex, e.idx);
                            chk("sampleSeq", bus.sampleSeq, e.seq);
                            chk("sampleTimeout", bus.sampleTimeout, e.to);
                        end
                    end
                end
                prev_start = bus.ciStart;
                prev_valid = bus.sampleValid;
                prev_ready = bus.sampleReady;
            end else begin
                prev_start = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end
            held.data = bus.sampleData;
            held.idx  = bus.sampleIndex;
            held.seq  = bus.sampleSeq;
            held.to   = bus.sampleTimeout;
        end
    end

    task automatic pulse_snap();
        snapReq = 1'b1;
        @(negedge clock);
        snapReq = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (2) @(negedge clock);
        while ((busy || exp_q.size() != 0) && n < 600) begin
            @(negedge clock);
            n++;
        end
        chk({"idle_", tag}, (n < 600), 1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ciStart"}, bus.ciStart, 0);
        chk({tag, "_ciN"}, bus.ciN, 0);
        chk({tag, "_ciValueA"}, bus.ciValueA, 0);
        chk({tag, "_ciValueB"}, bus.ciValueB, 0);
        chk({tag, "_sampleValid"}, bus.sampleValid, 0);
        chk({tag, "_sampleData"}, bus.sampleData, 0);
        chk({tag, "_sampleIndex"}, bus.sampleIndex, 0);
        chk({tag, "_sampleSeq"}, bus.sampleSeq, 0);
        chk({tag, "_sampleTimeout"}, bus.sampleTimeout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeoutCount"}, timeoutCount, 0);
    endtask

    initial begin
        int e;
        int n0;
        controlWord = CW_EN | CW_CLR;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset = 1'b0;

        // periodic frames, combinational responder
        @(negedge clock);
        n0 = start_q.size();
        period = 32'd20;
        enable = 1'b1;
        e = cyc;
        repeat (70) @(negedge clock);
        enable = 1'b0;
        wait_idle("periodic");
        repeat (30) @(negedge clock);
        chk("periodic_frames", start_q.size() - n0, 3);
        for (int k = 0; k < 3; k++) chk("periodic_start", start_q[n0 + k], e + 20 * (k + 1));

        // delayed responder
        mode = 2;
        controlWord = CW_DIS | 12'h00A;
        pulse_snap();
        wait_idle("lat3");

        // responder never answers, then the 15/16-cycle boundary
        mode = 3;
        pulse_snap();
        wait_idle("timeout");
        chk("timeoutCount_frame", timeoutCount, m_tout);
        mode = 4;
        pulse_snap();
        wait_idle("boundary");
        chk("timeoutCount_boundary", timeoutCount, m_tout);

        // backpressure on index 1
        mode = 0;
        hold_arm = 1'b1;
        pulse_snap();
        wait_idle("hold");

        // snapReq while busy is dropped
        n0 = start_q.size();
        pulse_snap();
        repeat (3) @(negedge clock);
        pulse_snap();
        wait_idle("snap_busy");
        repeat (5) @(negedge clock);
        chk("snap_busy_frames", start_q.size() - n0, 1);

        // snapReq coinciding with the periodic tick
        n0 = start_q.size();
        period = 32'd20;
        enable = 1'b1;
        e = cyc;
        while (cyc < e + 19) @(negedge clock);
        pulse_snap();
        repeat (4) @(negedge clock);
        enable = 1'b0;
        wait_idle("coincide");
        repeat (25) @(negedge clock);
        chk("coincide_frames", start_q.size() - n0, 1);
        chk("coincide_start", start_q[n0], e + 20);

        // randomized traffic
        mode = 1;
        ready_mode = 1;
        repeat (1500) begin
            @(negedge clock);
            if ($urandom_range(0, 99) == 0) begin
                enable = ~enable;
                period = $urandom_range(0, 40);
            end
            snapReq = ($urandom_range(0, 29) == 0);
            if (!busy && $urandom_range(0, 19) == 0) controlWord = 12'($urandom);
        end
        snapReq = 1'b0;
        enable  = 1'b0;
        wait_idle("random");
        chk("timeoutCount_random", timeoutCount, m_tout);

        // reset in WAIT; the late done must be ignored
        mode = 5;
        ready_mode = 0;
        pulse_snap();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        arr_q.delete();
        m_idx = 0;
        m_seq = 0;
        m_tout = 0;
        @(negedge clock);
        check_quiet("midreset");
        reset = 1'b0;
        repeat (12) @(negedge clock);
        chk("late_done_busy", busy, 0);
        chk("late_done_valid", bus.sampleValid, 0);
        mode = 0;
        pulse_snap();
        wait_idle("after_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("arrivals_empty", arr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
